pawn_dispatcher: RTL and testbench
==================================

Name: pawn_dispatcher

Overview:
- Drives the slave (control) port of the `pawn` move generator.
- Scans a 64-square board in SDRAM through its own Avalon-MM master and selects squares holding a pawn of the chosen colour.
- For each selected square, runs the generator register sequence: board addr, dest addr, x, y, start, poll.
- Packs the generated boards back-to-back at the destination and reports the total board count to the CPU.

Parameters:
NUM_SQUARES, 64, squares per board; square i = y*8 + x.
WORD_BYTES, 4, bytes per square word in SDRAM (piece code in bits [7:0], signed).
BOARD_BYTES, 256, destination stride per generated board (NUM_SQUARES*WORD_BYTES).

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
slave_waitrequest  output  1  CPU slave stall
slave_address  input  4  CPU register index
slave_read  input  1  CPU read strobe
slave_readdata  output  32  CPU read data
slave_write  input  1  CPU write strobe
slave_writedata  input  32  CPU write data
master_waitrequest  input  1  SDRAM stall
master_address  output  32  SDRAM byte address
master_read  output  1  SDRAM read strobe
master_readdata  input  32  SDRAM read data
master_readdatavalid  input  1  SDRAM read data valid
gen_waitrequest  input  1  generator slave stall
gen_address  output  4  generator register index
gen_read  output  1  generator read strobe
gen_readdata  input  32  generator read data: boards written
gen_write  output  1  generator write strobe
gen_writedata  output  32  generator write data

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all strobes 0; addresses and write data 0; slave_waitrequest 0; slave_readdata 0; total 0; all registers 0; state IDLE.
- CPU registers:
  - 1: board base address.
  - 2: destination base address.
  - 3: colour. bit0=0 selects white, codes 1..8; bit0=1 selects black, codes -1..-8 (0xFF..0xF8).
  - 0, write: start, writedata ignored.
  - 0, read: while busy, slave_waitrequest=1 and the read stalls; completes the cycle after DONE with readdata = total. If idle, completes immediately with the last total.
  - Reads of registers 1-3 return the stored value with no wait.
- Writes to any register while busy are accepted (waitrequest 0) and ignored.
- SDRAM reads:
  - Address = board_base + i*WORD_BYTES.
  - Hold master_read and master_address until a rising edge with master_waitrequest=0.
  - One outstanding read only; wait for master_readdatavalid before the next square.
- Generator transfers:
  - Hold gen_address, gen_writedata and the strobe until a rising edge with gen_waitrequest=0; that edge completes the transfer.
  - gen_readdata is sampled on the completing edge of a read.
  - Never assert gen_read and gen_write together.
- FSM:
  - IDLE -> RD_SQ on start; i=0, dst=dest_base, total=0.
  - RD_SQ -> RD_WAIT on accept; RD_WAIT -> CHECK on readdatavalid (latch code).
  - CHECK -> G_BRD if the code is in the selected range; otherwise -> NEXT.
  - G_BRD: write reg1 = board_base. G_DST: write reg2 = dst. G_X: write reg3 = i[2:0]. G_Y: write reg4 = i[5:3]. G_GO: write reg0 = 0.
  - G_POLL: read reg0. On completion n = gen_readdata; total += n; dst += n*BOARD_BYTES.
  - NEXT: if i == NUM_SQUARES-1 -> DONE, else i++ -> RD_SQ.
  - DONE -> IDLE after one cycle.
- n=0 is legal: dst is unchanged and dispatch continues.
- Arithmetic: total and dst are 32-bit and wrap silently.
- Reset mid-operation drops all strobes immediately (asynchronously); an in-flight transfer is abandoned.
- Latency: minimum 3 cycles per non-pawn square (RD_SQ, RD_WAIT, CHECK) plus NEXT; 64-square scan of an empty board with zero-wait SDRAM completes in ≤ 4*64+2 cycles.

Test Plan:
- White pawn (code 0x01) at square 10, others 0; dest=0x1000; mock generator returns 2 → gen writes in order reg1=0, reg2=0x1000, reg3=2, reg4=1, reg0; one reg0 read; 64 SDRAM reads at 0,4,...,252; CPU read reg0 returns 2.
- White pawns at squares 9 and 12; generator returns 2 then 1 → second dispatch has reg2=0x1200 (dest+512); total=3.
- Colour=1; board has 0xFC at square 50 and 0x03 at square 8 → exactly one dispatch with x=2, y=6; total equals generator return.
- Stall stress: gen_waitrequest high 3 cycles per transfer; random master_waitrequest; readdatavalid delayed 5 cycles → identical transfer sequence, no duplicated or dropped transfers, strobes held stable while stalled.
- Assert rst_n=0 during G_POLL → all strobes 0 before the next edge; after release, a new start scans from square 0 and total restarts at 0.
- CPU read reg0 right after reset with no start → completes with waitrequest 0 and readdata 0; write to reg1 while busy → the running scan keeps its original board_base.

Source files
------------

// File: rtl/pawn_dispatcher.sv
// pawn_dispatcher: walks a 64-square board held in SDRAM and, for every square that
// holds a pawn of the selected colour, drives the pawn generator's control registers
// to produce that pawn's moves. The generated boards are packed back-to-back at the
// destination, and the total number of boards produced is reported to the CPU.
//
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   slave_*                    CPU control port: reg0 start/total, reg1 board base,
//                              reg2 destination base, reg3 colour (bit0 = 1 selects black)
//   master_*                   SDRAM read master, one outstanding read at a time
//   gen_*                      master port into the pawn generator's control slave
module pawn_dispatcher #(
    parameter int unsigned NUM_SQUARES = 64,
    parameter int unsigned WORD_BYTES  = 4,
    parameter int unsigned BOARD_BYTES = NUM_SQUARES * WORD_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    // CPU slave
    output logic        slave_waitrequest_o,
    input  logic [3:0]  slave_address_i,
    input  logic        slave_read_i,
    output logic [31:0] slave_readdata_o,
    input  logic        slave_write_i,
    input  logic [31:0] slave_writedata_i,
    // SDRAM master
    input  logic        master_waitrequest_i,
    output logic [31:0] master_address_o,
    output logic        master_read_o,
    input  logic [31:0] master_readdata_i,
    input  logic        master_readdatavalid_i,
    // Generator control master
    input  logic        gen_waitrequest_i,
    output logic [3:0]  gen_address_o,
    output logic        gen_read_o,
    input  logic [31:0] gen_readdata_i,
    output logic        gen_write_o,
    output logic [31:0] gen_writedata_o
);

    localparam int unsigned IdxW = $clog2(NUM_SQUARES);

    typedef enum logic [3:0] {
        StIdle,
        StRdSq,
        StRdWait,
        StCheck,
        StGBrd,
        StGDst,
        StGX,
        StGY,
        StGGo,
        StGPoll,
        StNext,
        StDone
    } state_e;

    state_e            state_q;
    logic [31:0]       base_q;
    logic [31:0]       dest_q;
    logic [31:0]       colour_q;
    logic [31:0]       total_q;
    logic [31:0]       dst_q;
    logic [IdxW-1:0]   idx_q;
    logic [7:0]        code_q;

    logic              master_read_q;
    logic [31:0]       master_address_q;
    logic              gen_read_q;
    logic              gen_write_q;
    logic [3:0]        gen_address_q;
    logic [31:0]       gen_writedata_q;

    logic              busy;
    logic              start;
    logic              is_pawn;
    logic              last_sq;
    logic [IdxW-1:0]   next_idx;
    logic [31:0]       next_sq_addr;
    logic [31:0]       dst_step;
    logic signed [7:0] code_s;

    // Only the piece code in the low byte of a square word matters.
    logic              unused_rdata;
    assign unused_rdata = ^master_readdata_i[31:8];

    always_comb begin
        busy         = (state_q != StIdle);
        start        = slave_write_i && (slave_address_i == 4'd0) && !busy;
        code_s       = code_q;
        // White pawns are codes 1..8, black pawns are -1..-8.
        is_pawn      = colour_q[0] ? ((code_s >= -8'sd8) && (code_s <= -8'sd1))
                                   : ((code_s >= 8'sd1) && (code_s <= 8'sd8));
        last_sq      = (idx_q == IdxW'(NUM_SQUARES - 1));
        next_idx     = idx_q + IdxW'(1);
        next_sq_addr = base_q + 32'(next_idx) * WORD_BYTES;
        dst_step     = gen_readdata_i * BOARD_BYTES;
    end

    // A read of reg0 stalls the CPU until the scan has fully returned to idle.
    always_comb begin
        slave_waitrequest_o = slave_read_i && (slave_address_i == 4'd0) && busy;
        slave_readdata_o    = '0;
        if (slave_read_i) begin
            case (slave_address_i)
                4'd0:    slave_readdata_o = total_q;
                4'd1:    slave_readdata_o = base_q;
                4'd2:    slave_readdata_o = dest_q;
                4'd3:    slave_readdata_o = colour_q;
                default: slave_readdata_o = '0;
            endcase
        end
    end

    assign master_read_o    = master_read_q;
    assign master_address_o = master_address_q;
    assign gen_read_o       = gen_read_q;
    assign gen_write_o      = gen_write_q;
    assign gen_address_o    = gen_address_q;
    assign gen_writedata_o  = gen_writedata_q;

    // Bus strobes are registered and set up on the edge that enters each state, so
    // each transfer state simply waits for its own accepting edge and then loads the
    // next transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            base_q           <= '0;
            dest_q           <= '0;
            colour_q         <= '0;
            total_q          <= '0;
            dst_q            <= '0;
            idx_q            <= '0;
            code_q           <= '0;
            master_read_q    <= 1'b0;
            master_address_q <= '0;
            gen_read_q       <= 1'b0;
            gen_write_q      <= 1'b0;
            gen_address_q    <= '0;
            gen_writedata_q  <= '0;
        end else begin
            // Configuration writes land only while idle; writes during a scan are dropped.
            if (slave_write_i && !busy) begin
                case (slave_address_i)
                    4'd1:    base_q   <= slave_writedata_i;
                    4'd2:    dest_q   <= slave_writedata_i;
                    4'd3:    colour_q <= slave_writedata_i;
                    default: ;
                endcase
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        idx_q            <= '0;
                        dst_q            <= dest_q;
                        total_q          <= '0;
                        master_read_q    <= 1'b1;
                        master_address_q <= base_q;
                        state_q          <= StRdSq;
                    end
                end
                StRdSq: begin
                    if (!master_waitrequest_i) begin
                        master_read_q <= 1'b0;
                        state_q       <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (master_readdatavalid_i) begin
                        code_q  <= master_readdata_i[7:0];
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (is_pawn) begin
                        gen_write_q     <= 1'b1;
                        gen_address_q   <= 4'd1;
                        gen_writedata_q <= base_q;
                        state_q         <= StGBrd;
                    end else begin
                        state_q <= StNext;
                    end
                end
                StGBrd: begin
                    if (!gen_waitrequest_i) begin
                        gen_address_q   <= 4'd2;
                        gen_writedata_q <= dst_q;
                        state_q         <= StGDst;
                    end
                end
                StGDst: begin
                    if (!gen_waitrequest_i) begin
                        gen_address_q   <= 4'd3;
                        gen_writedata_q <= 32'(idx_q[2:0]);
                        state_q         <= StGX;
                    end
                end
                StGX: begin
                    if (!gen_waitrequest_i) begin
                        gen_address_q   <= 4'd4;
                        gen_writedata_q <= 32'(idx_q[IdxW-1:3]);
                        state_q         <= StGY;
                    end
                end
                StGY: begin
                    if (!gen_waitrequest_i) begin
                        gen_address_q   <= 4'd0;
                        gen_writedata_q <= '0;
                        state_q         <= StGGo;
                    end
                end
                StGGo: begin
                    // Swap write for read in one edge; the two never overlap.
                    if (!gen_waitrequest_i) begin
                        gen_write_q   <= 1'b0;
                        gen_read_q    <= 1'b1;
                        gen_address_q <= 4'd0;
                        state_q       <= StGPoll;
                    end
                end
                StGPoll: begin
                    if (!gen_waitrequest_i) begin
                        gen_read_q <= 1'b0;
                        total_q    <= total_q + gen_readdata_i;
                        dst_q      <= dst_q + dst_step;
                        state_q    <= StNext;
                    end
                end
                StNext: begin
                    if (last_sq) begin
                        state_q <= StDone;
                    end else begin
                        idx_q            <= next_idx;
                        master_read_q    <= 1'b1;
                        master_address_q <= next_sq_addr;
                        state_q          <= StRdSq;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pawn_dispatcher.sv
// tb_pawn_dispatcher: randomised and directed bench for pawn_dispatcher. Mock SDRAM and
// mock generator respond at the falling edge; every accepted transfer is compared against
// queues built by a square-by-square model of the dispatch rules.
module tb_pawn_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        gen_waitrequest;
    logic [3:0]  gen_address;
    logic        gen_read;
    logic [31:0] gen_readdata;
    logic        gen_write;
    logic [31:0] gen_writedata;

    always #5 clk = ~clk;

    pawn_dispatcher dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .slave_waitrequest_o    (slave_waitrequest),
        .slave_address_i        (slave_address),
        .slave_read_i           (slave_read),
        .slave_readdata_o       (slave_readdata),
        .slave_write_i          (slave_write),
        .slave_writedata_i      (slave_writedata),
        .master_waitrequest_i   (master_waitrequest),
        .master_address_o       (master_address),
        .master_read_o          (master_read),
        .master_readdata_i      (master_readdata),
        .master_readdatavalid_i (master_readdatavalid),
        .gen_waitrequest_i      (gen_waitrequest),
        .gen_address_o          (gen_address),
        .gen_read_o             (gen_read),
        .gen_readdata_i         (gen_readdata),
        .gen_write_o            (gen_write),
        .gen_writedata_o        (gen_writedata)
    );

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } gen_t;

    int          checks = 0;
    int          errors = 0;
    byte         board [64];
    gen_t        exp_gen [$];
    logic [31:0] exp_sd [$];
    logic [31:0] exp_total;
    int unsigned ret_plan [$];
    int unsigned ret_q [$];
    logic [31:0] cur_base;
    bit          stress = 1'b0;
    bit          gen_hold = 1'b0;

    // Responder state
    bit          pend = 1'b0;
    int          pend_cnt;
    logic [5:0]  pend_idx;
    bit          m_stall_prev = 1'b0;
    logic [31:0] m_prev_addr;
    bit          g_stall_prev = 1'b0;
    logic [37:0] g_prev;
    int          gcnt = 0;
    logic [31:0] rnd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Square-by-square model of what the dispatcher must do for the current board.
    task automatic build_model(input logic [31:0] colour, input logic [31:0] base,
                               input logic [31:0] dest);
        logic [31:0] dst;
        logic [31:0] tot;
        int          k;
        int          c;
        bit          sel;
        int unsigned n;
        gen_t        g;
        dst = dest;
        tot = 0;
        k   = 0;
        exp_gen.delete();
        exp_sd.delete();
        for (int i = 0; i < 64; i++) begin
            exp_sd.push_back(base + 32'(i) * 32'd4);
            c   = board[i];
            sel = colour[0] ? (c >= -8 && c <= -1) : (c >= 1 && c <= 8);
            if (sel) begin
                g.wr = 1; g.addr = 4'd1; g.data = base;         exp_gen.push_back(g);
                g.wr = 1; g.addr = 4'd2; g.data = dst;          exp_gen.push_back(g);
                g.wr = 1; g.addr = 4'd3; g.data = 32'(i % 8);   exp_gen.push_back(g);
                g.wr = 1; g.addr = 4'd4; g.data = 32'(i / 8);   exp_gen.push_back(g);
                g.wr = 1; g.addr = 4'd0; g.data = 32'd0;        exp_gen.push_back(g);
                g.wr = 0; g.addr = 4'd0; g.data = 32'd0;        exp_gen.push_back(g);
                n = (k < ret_plan.size()) ? ret_plan[k] : 0;
                k++;
                tot = tot + n;
                dst = dst + n * 256;
            end
        end
        exp_total = tot;
    endtask

    // Mock SDRAM and mock generator; also the per-cycle compare process.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend                 = 0;
            gcnt                 = 0;
            m_stall_prev         = 0;
            g_stall_prev         = 0;
            master_readdatavalid = 0;
            master_waitrequest   = 0;
            gen_waitrequest      = 0;
        end else begin
            rnd                  = $urandom;
            master_readdatavalid = 0;
            master_readdata      = $urandom;
            if (pend) begin
                if (pend_cnt == 0) begin
                    master_readdatavalid = 1;
                    master_readdata      = {rnd[31:8], board[pend_idx]};
                    pend                 = 0;
                end else begin
                    pend_cnt--;
                end
            end
            if (m_stall_prev)
                chk("sdram hold", {31'd0, master_read, master_address}, {31'd0, 1'b1, m_prev_addr});
            master_waitrequest = stress && ($urandom_range(0, 2) != 0);
            if (master_read && !master_waitrequest) begin
                if (pend || master_readdatavalid) begin
                    errors++;
                    $display("FAIL sdram outstanding: second read at %0h", master_address);
                end
                if (exp_sd.size() == 0) begin
                    errors++;
                    $display("FAIL sdram extra: read at %0h, none expected", master_address);
                end else begin
                    chk("sdram addr", 64'(master_address), 64'(exp_sd.pop_front()));
                end
                pend     = 1;
                pend_cnt = stress ? 5 : 0;
                pend_idx = 6'((master_address - cur_base) >> 2);
            end
            m_stall_prev = master_read && master_waitrequest;
            m_prev_addr  = master_address;

            if (g_stall_prev)
                chk("gen hold", 64'({gen_read, gen_write, gen_address, gen_writedata}), 64'(g_prev));
            if (gen_read && gen_write) begin
                errors++;
                $display("FAIL gen strobes: read and write both 1, required one");
            end
            gen_readdata = $urandom;
            if (gen_read || gen_write) begin
                if (gen_hold && gen_read) begin
                    gen_waitrequest = 1;
                end else if (stress && gcnt < 3) begin
                    gen_waitrequest = 1;
                    gcnt++;
                end else begin
                    gen_waitrequest = 0;
                    gcnt            = 0;
                    if (exp_gen.size() == 0) begin
                        errors++;
                        $display("FAIL gen extra: wr=%0b addr=%0d data=%0h, none expected",
                                 gen_write, gen_address, gen_writedata);
                    end else begin
                        gen_t g;
                        g = exp_gen.pop_front();
                        chk("gen xfer",
                            {27'd0, gen_write, gen_address, gen_write ? gen_writedata : 32'd0},
                            {27'd0, g.wr, g.addr, g.wr ? g.data : 32'd0});
                    end
                    if (gen_read) gen_readdata = (ret_q.size() > 0) ? ret_q.pop_front() : 0;
                end
            end else begin
                gen_waitrequest = 0;
            end
            g_stall_prev = (gen_read || gen_write) && gen_waitrequest;
            g_prev       = {gen_read, gen_write, gen_address, gen_writedata};
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_write     = 1;
        slave_address   = a;
        slave_writedata = d;
        #1;
        chk("write waitrequest", 64'(slave_waitrequest), 64'd0);
        @(posedge clk);
        #1;
        slave_write = 0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int waits);
        @(negedge clk);
        slave_read    = 1;
        slave_address = a;
        waits         = 0;
        #1;
        while (slave_waitrequest && waits < 20000) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            waits++;
        end
        if (slave_waitrequest) begin
            errors++;
            $display("FAIL read timeout: reg%0d still stalled after %0d cycles", a, waits);
        end
        d = slave_readdata;
        @(posedge clk);
        #1;
        slave_read = 0;
    endtask

    task automatic prep(input logic [31:0] colour, input logic [31:0] base,
                        input logic [31:0] dest);
        cpu_write(4'd1, base);
        cpu_write(4'd2, dest);
        cpu_write(4'd3, colour);
        cur_base = base;
        ret_q    = ret_plan;
        build_model(colour, base, dest);
    endtask

    task automatic finish_scan(input string name, output int waits);
        logic [31:0] d;
        cpu_read(4'd0, d, waits);
        chk({name, " total"}, 64'(d), 64'(exp_total));
        chk({name, " gen left"}, 64'(exp_gen.size()), 64'd0);
        chk({name, " sdram left"}, 64'(exp_sd.size()), 64'd0);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          w;
        bit          found;

        rst_n           = 0;
        slave_address   = 0;
        slave_read      = 0;
        slave_write     = 0;
        slave_writedata = 0;
        master_readdata = 0;
        gen_readdata    = 0;
        #1;
        chk("reset strobes", {59'd0, master_read, gen_read, gen_write, slave_waitrequest, 1'b0}, 64'd0);
        chk("reset addrs", {master_address, 28'd0, gen_address}, 64'd0);
        chk("reset wdata/rdata", {gen_writedata, slave_readdata}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Idle read of reg0 right after reset: no stall, zero total.
        cpu_read(4'd0, d, w);
        chk("idle read total", 64'(d), 64'd0);
        chk("idle read waits", 64'(w), 64'd0);

        // One white pawn at square 10.
        clear_board();
        board[10] = 8'sh01;
        ret_plan  = '{2};
        prep(32'd0, 32'd0, 32'h1000);
        chk("model t1 reg2", 64'(exp_gen[1].data), 64'h1000);
        chk("model t1 x", 64'(exp_gen[2].data), 64'd2);
        chk("model t1 y", 64'(exp_gen[3].data), 64'd1);
        chk("model t1 last sdram", 64'(exp_sd[63]), 64'd252);
        cpu_write(4'd0, 32'hFFFF);
        finish_scan("t1", w);
        chk("t1 total literal", 64'(exp_total), 64'd2);

        // Two white pawns, generator returns 2 then 1.
        clear_board();
        board[9]  = 8'sh01;
        board[12] = 8'sh01;
        ret_plan  = '{2, 1};
        prep(32'd0, 32'd0, 32'h1000);
        chk("model t2 dst2", 64'(exp_gen[7].data), 64'h1200);
        chk("model t2 total", 64'(exp_total), 64'd3);
        cpu_write(4'd0, 32'd0);
        finish_scan("t2", w);

        // Black selection ignores the white code at square 8.
        clear_board();
        board[50] = 8'shFC;
        board[8]  = 8'sh03;
        ret_plan  = '{4};
        prep(32'd1, 32'h0100, 32'h4000);
        chk("model t3 n", 64'(exp_gen.size()), 64'd6);
        chk("model t3 x", 64'(exp_gen[2].data), 64'd2);
        chk("model t3 y", 64'(exp_gen[3].data), 64'd6);
        cpu_write(4'd0, 32'd0);
        finish_scan("t3", w);
        cpu_read(4'd3, d, w);
        chk("colour readback", 64'(d), 64'd1);

        // Empty board with zero-wait SDRAM: scan latency bound.
        clear_board();
        ret_plan = '{};
        prep(32'd0, 32'h0, 32'h0);
        cpu_write(4'd0, 32'd0);
        finish_scan("empty", w);
        checks++;
        if (w + 1 > 4 * 64 + 2) begin
            errors++;
            $display("FAIL empty latency: got %0d cycles, required <= %0d", w + 1, 4 * 64 + 2);
        end

        // Stall stress on the two-pawn board.
        stress = 1;
        clear_board();
        board[9]  = 8'sh01;
        board[12] = 8'sh08;
        ret_plan  = '{2, 1};
        prep(32'd0, 32'h0, 32'h1000);
        cpu_write(4'd0, 32'd0);
        finish_scan("stress", w);
        stress = 0;

        // Write to reg1 while busy must not disturb the running scan.
        clear_board();
        board[5] = 8'sh02;
        ret_plan = '{1};
        prep(32'd0, 32'h0400, 32'h8000);
        cpu_write(4'd0, 32'd0);
        cpu_write(4'd1, 32'hDEAD0000);
        finish_scan("busy write", w);
        cpu_read(4'd1, d, w);
        chk("base kept", 64'(d), 64'h0400);

        // Reset during the generator poll.
        clear_board();
        board[20] = 8'sh01;
        ret_plan  = '{5};
        gen_hold  = 1;
        prep(32'd0, 32'h0, 32'h0);
        cpu_write(4'd0, 32'd0);
        found = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (gen_read) found = 1;
        end
        chk("poll reached", 64'(found), 64'd1);
        #2;
        rst_n = 0;
        #1;
        chk("async drop", {61'd0, master_read, gen_read, gen_write}, 64'd0);
        exp_gen.delete();
        exp_sd.delete();
        ret_q.delete();
        gen_hold = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        cpu_read(4'd0, d, w);
        chk("post-reset total", 64'(d), 64'd0);
        clear_board();
        board[3]  = 8'sh01;
        board[20] = 8'sh01;
        ret_plan  = '{1, 1};
        prep(32'd0, 32'h2000, 32'h8000);
        cpu_write(4'd0, 32'd0);
        finish_scan("post-reset", w);

        // Randomised boards, colours and stalls.
        for (int t = 0; t < 4; t++) begin
            logic [31:0] col;
            logic [31:0] base;
            logic [31:0] dest;
            stress = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 64; i++)
                board[i] = ($urandom_range(0, 3) == 0) ? byte'(int'($urandom_range(0, 18)) - 9) : 0;
            ret_plan.delete();
            for (int i = 0; i < 64; i++) ret_plan.push_back($urandom_range(0, 3));
            col  = 32'($urandom_range(0, 1));
            base = $urandom & 32'hFFFF_FFFC;
            dest = $urandom;
            prep(col, base, dest);
            cpu_write(4'd0, 32'd0);
            finish_scan("random", w);
        end
        stress = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
